multi_lane_game: RTL and testbench

MULTI_LANE_GAME -- requirements
Module: multi_lane_game

---
 rtl/multi_lane_game_pkg.sv | 23 ++
 rtl/multi_lane_game_lane_scorer.sv | 78 +++++++
 rtl/multi_lane_game.sv | 163 ++++++++++++++++
 tb/tb_multi_lane_game.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_lane_game_pkg.sv
// game_pkg: shared definitions for the multi-lane rhythm game.
//   state_e    : top-level game state encoding (IDLE/PLAY/OVER)
//   MULT_CAP   : highest score multiplier a combo can earn
//   COMBO_STEP : combo length needed to raise the multiplier by one
//   sat_add    : add two non-negative values, clamped to a ceiling
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int MULT_CAP   = 4;
  localparam int COMBO_STEP = 8;

  function automatic int sat_add(input int a, input int b, input int max_val);
    int sum;
    sum = a + b;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/multi_lane_game_lane_scorer.sv
// lane_scorer: one note lane of the game.
//   clk, rst    : clock, asynchronous active-high reset
//   button      : raw asynchronous button for this lane
//   song        : this lane's note pattern, bit 0 played first
//   load        : start of game, load song and clear the consumed flag
//   play        : game is running, presses are scored
//   tick        : scroll event, notes move down one slot
//   disp        : visible window, bit 0 = target slot
//   lane_hit    : press landed on a live target note (this cycle)
//   press_miss  : press with no live target note (this cycle)
//   tick_miss   : live target note scrolled away unplayed (this cycle)
module lane_scorer
  import game_pkg::*;
#(
  parameter int SONG_LEN = 32,
  parameter int DISP_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button,
  input  logic [SONG_LEN-1:0] song,
  input  logic                load,
  input  logic                play,
  input  logic                tick,
  output logic [DISP_LEN-1:0] disp,
  output logic                lane_hit,
  output logic                press_miss,
  output logic                tick_miss
);

  localparam int SR_W = SONG_LEN + DISP_LEN;

  logic            sync1, sync2, sync3;
  logic [SR_W-1:0] notes;
  logic            consumed;
  logic            press;
  logic            target_live;

  // sync1/sync2 form the synchronizer, sync3 holds the previous level for
  // rising-edge detection.
  assign press       = sync2 & ~sync3;
  assign target_live = notes[0] & ~consumed;

  // A press is judged against the pre-shift target, so a hit on a tick cycle
  // also suppresses that cycle's tick miss.
  assign lane_hit    = play & press & target_live;
  assign press_miss  = play & press & ~target_live;
  assign tick_miss   = tick & target_live & ~lane_hit;

  always_comb begin
    disp    = notes[DISP_LEN-1:0];
    disp[0] = target_live;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      notes    <= '0;
      consumed <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      sync3 <= sync2;
      if (load) begin
        notes    <= {{DISP_LEN{1'b0}}, song};
        consumed <= 1'b0;
      end else if (tick) begin
        notes    <= notes >> 1;
        consumed <= 1'b0;
      end else if (lane_hit) begin
        consumed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_lane_game.sv
// multi_lane_game: rhythm game controller with NUM_LANES note lanes.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : pulse, begin a game from IDLE / acknowledge OVER
//   diff            : scroll period in clk cycles (0 treated as 1)
//   song            : per-lane note patterns, lane L at [L*SONG_LEN +: SONG_LEN]
//   buttons         : raw asynchronous buttons, one per lane
//   disp            : per-lane visible window, bit 0 = target slot
//   num_hits, num_misses, score, combo : saturating statistics
//   lives           : remaining lives
//   hit, missed     : one-cycle pulses, any lane
//   state           : IDLE / PLAY / OVER
//
// state | meaning
// IDLE  | waiting for start, statistics hold last game's values
// PLAY  | notes scroll, presses and missed notes are scored
// OVER  | out of lives or song finished, waiting for start to acknowledge
module multi_lane_game
  import game_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int SONG_LEN  = 32,
  parameter int DISP_LEN  = 8,
  parameter int DIV_W     = 23,
  parameter int CNT_W     = 8,
  parameter int MAX_LIVES = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DIV_W-1:0]                  diff,
  input  logic [NUM_LANES*SONG_LEN-1:0]     song,
  input  logic [NUM_LANES-1:0]              buttons,
  output logic [NUM_LANES*DISP_LEN-1:0]     disp,
  output logic [CNT_W-1:0]                  num_hits,
  output logic [CNT_W-1:0]                  num_misses,
  output logic [CNT_W-1:0]                  score,
  output logic [CNT_W-1:0]                  combo,
  output logic [$clog2(MAX_LIVES+1)-1:0]    lives,
  output logic                              hit,
  output logic                              missed,
  output logic [1:0]                        state
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] PLAY = ST_PLAY;
  localparam logic [1:0] OVER = ST_OVER;

  localparam int LW        = $clog2(MAX_LIVES + 1);
  localparam int TOTAL     = SONG_LEN + DISP_LEN;
  localparam int TW        = $clog2(TOTAL + 1);
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     period;
  logic [DIV_W-1:0]     period_now;
  logic [TW-1:0]        tick_cnt;
  logic                 play;
  logic                 load;
  logic                 tick;
  logic                 song_done;
  logic [NUM_LANES-1:0] lane_hit;
  logic [NUM_LANES-1:0] press_miss;
  logic [NUM_LANES-1:0] tick_miss;

  int h, m, mult, lives_n;

  assign play       = (state == PLAY);
  assign load       = (state == IDLE) && start;
  assign period_now = (diff == '0) ? DIV_W'(1) : diff;
  // The period is latched at game start and at every wrap, so a new diff
  // only takes effect from the next scroll slot.
  assign tick       = play && (div_cnt == period - 1'b1);
  assign song_done  = tick && (tick_cnt == TW'(TOTAL - 1));

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_scorer #(
      .SONG_LEN (SONG_LEN),
      .DISP_LEN (DISP_LEN)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .button     (buttons[l]),
      .song       (song[l*SONG_LEN +: SONG_LEN]),
      .load       (load),
      .play       (play),
      .tick       (tick),
      .disp       (disp[l*DISP_LEN +: DISP_LEN]),
      .lane_hit   (lane_hit[l]),
      .press_miss (press_miss[l]),
      .tick_miss  (tick_miss[l])
    );
  end

  always_comb begin
    h = 0;
    m = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      h = h + int'(lane_hit[i]);
      m = m + int'(press_miss[i]) + int'(tick_miss[i]);
    end
    // Multiplier is earned by the combo standing before this cycle's hits.
    mult = 1 + int'(combo) / COMBO_STEP;
    if (mult > MULT_CAP) mult = MULT_CAP;
    lives_n = (m >= int'(lives)) ? 0 : int'(lives) - m;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      period     <= '0;
      tick_cnt   <= '0;
      num_hits   <= '0;
      num_misses <= '0;
      score      <= '0;
      combo      <= '0;
      lives      <= '0;
      hit        <= 1'b0;
      missed     <= 1'b0;
    end else begin
      hit    <= 1'b0;
      missed <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= PLAY;
            div_cnt    <= '0;
            period     <= period_now;
            tick_cnt   <= '0;
            num_hits   <= '0;
            num_misses <= '0;
            score      <= '0;
            combo      <= '0;
            lives      <= LW'(MAX_LIVES);
          end
        end
        PLAY: begin
          if (tick) begin
            div_cnt  <= '0;
            period   <= period_now;
            tick_cnt <= tick_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          num_hits   <= CNT_W'(sat_add(int'(num_hits), h, CNT_MAX));
          num_misses <= CNT_W'(sat_add(int'(num_misses), m, CNT_MAX));
          score      <= CNT_W'(sat_add(int'(score), h * mult, CNT_MAX));
          // Any miss breaks the combo, even alongside hits in the same cycle.
          combo      <= (m > 0) ? '0 : CNT_W'(sat_add(int'(combo), h, CNT_MAX));
          lives      <= LW'(lives_n);
          hit        <= (h > 0);
          missed     <= (m > 0);
          if (lives_n == 0 || song_done) state <= OVER;
        end
        OVER: begin
          if (start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_lane_game.sv
module tb_multi_lane_game;

  logic         clk;
  logic         rst;
  logic         start;
  logic [22:0]  diff;
  logic [127:0] song;
  logic [3:0]   buttons;
  logic [31:0]  disp;
  logic [7:0]   num_hits, num_misses, score, combo;
  logic [3:0]   lives;
  logic         hit, missed;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_score [8] = '{8'd4, 8'd8, 8'd16, 8'd24, 8'd36, 8'd48, 8'd64, 8'd80};

  multi_lane_game dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .diff       (diff),
    .song       (song),
    .buttons    (buttons),
    .disp       (disp),
    .num_hits   (num_hits),
    .num_misses (num_misses),
    .score      (score),
    .combo      (combo),
    .lives      (lives),
    .hit        (hit),
    .missed     (missed),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle into PLAY ("cycle 0").
  task automatic start_game();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; diff = 23'd4; song = '0; buttons = '0;
    step(2);
    check("rst_state",  state, 2'd0);
    check("rst_lives",  lives, 4'd0);
    check("rst_disp",   disp,  32'h0);
    check("rst_pulses", {hit, missed}, 2'b00);
    rst = 1'b0;
    step(1);

    // Single hit on lane 0, press reaching the scorer in PLAY cycle 1.
    diff = 23'd4;
    song = 128'h0;
    song[7:0] = 8'hA5;
    buttons = 4'b0001;
    start_game();
    check("t1_state_play", state, 2'd1);
    check("t1_disp_load",  disp, 32'h0000_00A5);
    step(2);
    buttons = 4'b0000;
    check("t1_hit",      hit, 1'b1);
    check("t1_num_hits", num_hits, 8'd1);
    check("t1_score",    score, 8'd1);
    check("t1_combo",    combo, 8'd1);
    check("t1_disp_consumed", disp, 32'h0000_00A4);
    step(1);
    check("t1_hit_pulse_end", hit, 1'b0);
    step(1);
    check("t1_no_tick_miss", num_misses, 8'd0);
    check("t1_disp_shift",   disp, 32'h0000_0052);

    // Asynchronous reset mid-PLAY.
    rst = 1'b1;
    #1;
    check("t2_async_state", state, 2'd0);
    check("t2_async_stats", {num_hits, num_misses, score, combo}, 32'h0);
    check("t2_async_lives", lives, 4'd0);
    check("t2_async_disp",  disp, 32'h0);
    step(1);
    rst = 1'b0;
    step(1);
    check("t2_idle_hold", state, 2'd0);

    // Replay from bit 0; lane0 hit and lane1 empty press in the same cycle.
    start_game();
    check("t2_replay_disp", disp, 32'h0000_00A5);
    buttons = 4'b0011;
    step(1);
    buttons = 4'b0000;
    step(2);
    check("t3_num_hits",   num_hits, 8'd1);
    check("t3_num_misses", num_misses, 8'd1);
    check("t3_combo",      combo, 8'd0);
    check("t3_lives",      lives, 4'd7);
    check("t3_score",      score, 8'd1);
    check("t3_pulses",     {hit, missed}, 2'b11);
    step(1);
    check("t3_no_tick_miss", num_misses, 8'd1);

    // Press on the tick cycle, then twice within the next slot.
    do_reset();
    diff = 23'd4;
    song = 128'h0;
    song[31:0] = 32'h3;
    start_game();
    step(1); buttons = 4'b0001;
    step(1); buttons = 4'b0000;
    step(1); buttons = 4'b0001;
    step(1); buttons = 4'b0000;
    check("t4_tick_hit",     num_hits, 8'd1);
    check("t4_tick_no_miss", num_misses, 8'd0);
    check("t4_tick_pulse",   hit, 1'b1);
    step(1); buttons = 4'b0001;
    step(1); buttons = 4'b0000;
    check("t4_second_hit", num_hits, 8'd2);
    check("t4_score",      score, 8'd2);
    step(2);
    check("t4_repress_miss", num_misses, 8'd1);
    check("t4_repress_hits", num_hits, 8'd2);
    check("t4_combo_break",  combo, 8'd0);
    check("t4_lives",        lives, 4'd7);
    check("t4_pulses",       {hit, missed}, 2'b01);

    // Four lanes hit together every slot; multiplier climbs with combo.
    do_reset();
    diff = 23'd4;
    song = {4{32'hFFFF_FFFF}};
    buttons = 4'b1111;
    start_game();
    buttons = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      step(2);
      check($sformatf("t5_hits_%0d", k),  num_hits, 8'(4 * (k + 1)));
      check($sformatf("t5_combo_%0d", k), combo, 8'(4 * (k + 1)));
      check($sformatf("t5_score_%0d", k), score, exp_score[k]);
      step(1); buttons = 4'b1111;
      step(1); buttons = 4'b0000;
    end
    check("t5_no_misses", num_misses, 8'd0);
    check("t5_lives",     lives, 4'd8);

    // Unplayed notes every 2 cycles drain all lives; start ignored in PLAY.
    do_reset();
    diff = 23'd2;
    song = 128'h0;
    song[31:0] = 32'hFFFF_FFFF;
    start_game();
    for (int k = 1; k <= 8; k++) begin
      step(1);
      start = 1'b0;
      if (k == 1) check("t6_no_early_miss", missed, 1'b0);
      step(1);
      check($sformatf("t6_missed_%0d", k), missed, 1'b1);
      check($sformatf("t6_lives_%0d", k),  lives, 4'(8 - k));
      check($sformatf("t6_state_%0d", k),  state, (k == 8) ? 2'd2 : 2'd1);
      if (k == 2) start = 1'b1;
    end
    check("t6_num_misses", num_misses, 8'd8);
    step(2);
    check("t6_over_hold", {state, num_misses}, {2'd2, 8'd8});
    start_game();
    check("t6_ack_idle",  state, 2'd0);
    check("t6_idle_hold", num_misses, 8'd8);

    // diff=0 behaves as period 1: song ends after SONG_LEN+DISP_LEN ticks.
    do_reset();
    diff = 23'd0;
    song = 128'h0;
    start_game();
    step(39);
    check("t7_still_play", state, 2'd1);
    step(1);
    check("t7_song_over", state, 2'd2);
    check("t7_lives",     lives, 4'd8);
    check("t7_no_misses", num_misses, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
